// File: rtl/vending_pkg.sv
// Shared state encoding and price-table helper for the multi-product vending controller.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CREDIT = 2'd1,
    VEND   = 2'd2,
    CHANGE = 2'd3
  } state_t;

  // Price vectors are zero-extended to this width before lookup.
  localparam int unsigned PRICE_VEC_W = 256;

  function automatic logic [31:0] price_at(input logic [PRICE_VEC_W-1:0] prices,
                                           input int unsigned idx,
                                           input int unsigned w);
    return 32'(prices >> (idx * w)) & ((32'd1 << w) - 32'd1);
  endfunction

endpackage

// File: rtl/vending_machine_multi.sv
// Multi-coin, multi-product vending controller: credit accumulation, sale,
// automatic one-unit-per-cycle change return and cancel refund.
module vending_machine_multi
  import vending_pkg::*;
#(
  parameter int N_PROD     = 2,
  parameter int SEL_W      = 1,
  parameter int VAL_W      = 3,
  parameter int CREDIT_W   = 5,
  parameter int MAX_CREDIT = 15,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES = {5'd5, 5'd3}
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                coin,
  input  logic [VAL_W-1:0]    coin_val,
  input  logic                buy,
  input  logic [SEL_W-1:0]    sel,
  input  logic                cancel,
  output logic                vend,
  output logic [SEL_W-1:0]    vend_sel,
  output logic                change,
  output logic                coin_reject,
  output logic                deny,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy
);

  localparam logic [PRICE_VEC_W-1:0] PRICES_EXT = PRICE_VEC_W'(PRICES);

  state_t              r_state, w_state_n;
  logic [CREDIT_W-1:0] r_credit, w_credit_n;
  logic                r_vend, w_vend_n;
  logic [SEL_W-1:0]    r_vend_sel, w_vend_sel_n;
  logic                r_change, w_change_n;
  logic                r_reject, w_reject_n;
  logic                r_deny, w_deny_n;
  logic                r_busy, w_busy_n;

  logic [31:0]         w_price;
  logic                w_sel_ok;
  logic                w_afford;
  logic [CREDIT_W:0]   w_sum;
  logic                w_coin_ok;

  // Sum is one bit wider than the credit so an over-ceiling coin cannot wrap.
  assign w_price   = price_at(PRICES_EXT, 32'(sel), CREDIT_W);
  assign w_sel_ok  = 32'(sel) < 32'(N_PROD);
  assign w_afford  = 32'(r_credit) >= w_price;
  assign w_sum     = {1'b0, r_credit} + (CREDIT_W+1)'(coin_val);
  assign w_coin_ok = (coin_val != '0) && (w_sum <= (CREDIT_W+1)'(MAX_CREDIT));

  always_comb begin
    w_state_n    = r_state;
    w_credit_n   = r_credit;
    w_vend_n     = 1'b0;
    w_vend_sel_n = r_vend_sel;
    w_reject_n   = 1'b0;
    w_deny_n     = 1'b0;

    unique case (r_state)
      IDLE, CREDIT: begin
        if (cancel) begin
          w_reject_n = coin;
          if (r_credit != '0) w_state_n = CHANGE;
        end else if (buy) begin
          w_reject_n = coin;
          if (!w_sel_ok || !w_afford) begin
            w_deny_n = 1'b1;
          end else begin
            w_state_n    = VEND;
            w_vend_n     = 1'b1;
            w_vend_sel_n = sel;
            w_credit_n   = CREDIT_W'(32'(r_credit) - w_price);
          end
        end else if (coin) begin
          if (w_coin_ok) begin
            w_credit_n = w_sum[CREDIT_W-1:0];
            w_state_n  = CREDIT;
          end else begin
            w_reject_n = 1'b1;
          end
        end
      end
      VEND: begin
        w_reject_n = coin;
        w_deny_n   = buy;
        w_state_n  = (r_credit != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        w_reject_n = coin;
        w_deny_n   = buy;
        w_credit_n = r_credit - CREDIT_W'(1);
        if (r_credit == CREDIT_W'(1)) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase

    // change is high for every cycle spent in CHANGE; credit shows the units still owed
    w_change_n = (w_state_n == CHANGE);
    w_busy_n   = (w_state_n == VEND) || (w_state_n == CHANGE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_credit   <= '0;
      r_vend     <= 1'b0;
      r_vend_sel <= '0;
      r_change   <= 1'b0;
      r_reject   <= 1'b0;
      r_deny     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_credit   <= w_credit_n;
      r_vend     <= w_vend_n;
      r_vend_sel <= w_vend_sel_n;
      r_change   <= w_change_n;
      r_reject   <= w_reject_n;
      r_deny     <= w_deny_n;
      r_busy     <= w_busy_n;
    end
  end

  assign vend        = r_vend;
  assign vend_sel    = r_vend_sel;
  assign change      = r_change;
  assign coin_reject = r_reject;
  assign deny        = r_deny;
  assign credit      = r_credit;
  assign busy        = r_busy;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a behavioural model.
module tb_vending_machine_multi;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       coin;
  logic [2:0] coin_val;
  logic       buy;
  logic [0:0] sel;
  logic       cancel;
  logic       vend;
  logic [0:0] vend_sel;
  logic       change;
  logic       coin_reject;
  logic       deny;
  logic [4:0] credit;
  logic       busy;

  vending_machine_multi #(
    .N_PROD(2), .SEL_W(1), .VAL_W(3), .CREDIT_W(5), .MAX_CREDIT(15),
    .PRICES({5'd5, 5'd3})
  ) dut (
    .clk(clk), .rst_n(rst_n), .coin(coin), .coin_val(coin_val), .buy(buy),
    .sel(sel), .cancel(cancel), .vend(vend), .vend_sel(vend_sel),
    .change(change), .coin_reject(coin_reject), .deny(deny),
    .credit(credit), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: credit as a plain integer; a sale occupies one cycle,
  // a refund pays out one unit per cycle while the display shows what is still owed.
  int   price [2] = '{3, 5};
  int   m_credit = 0;
  bit   m_vending = 0, m_refunding = 0, m_valid = 0;
  logic e_vend, e_change, e_rej, e_deny, e_busy;
  logic [0:0] e_sel;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_credit = 0; m_vending = 0; m_refunding = 0; m_valid = 1;
      e_vend = 0; e_change = 0; e_rej = 0; e_deny = 0; e_busy = 0; e_sel = 0;
    end else if (m_valid) begin
      e_vend = 0; e_rej = 0; e_deny = 0;
      if (m_vending) begin
        e_rej = coin; e_deny = buy;
        m_vending = 0;
        m_refunding = (m_credit > 0);
      end else if (m_refunding) begin
        e_rej = coin; e_deny = buy;
        m_credit = m_credit - 1;
        m_refunding = (m_credit > 0);
      end else if (cancel) begin
        e_rej = coin;
        if (m_credit > 0) m_refunding = 1;
      end else if (buy) begin
        e_rej = coin;
        if (int'(sel) >= 2 || m_credit < price[sel]) e_deny = 1;
        else begin
          m_credit = m_credit - price[sel];
          m_vending = 1; e_vend = 1; e_sel = sel;
        end
      end else if (coin) begin
        if (coin_val == 0 || m_credit + int'(coin_val) > 15) e_rej = 1;
        else m_credit = m_credit + int'(coin_val);
      end
      e_change = m_refunding;
      e_busy   = m_vending || m_refunding;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("vend",        32'(vend),        32'(e_vend));
      chk("vend_sel",    32'(vend_sel),    32'(e_sel));
      chk("change",      32'(change),      32'(e_change));
      chk("coin_reject", 32'(coin_reject), 32'(e_rej));
      chk("deny",        32'(deny),        32'(e_deny));
      chk("credit",      32'(credit),      32'(m_credit));
      chk("busy",        32'(busy),        32'(e_busy));
    end
  end

  task automatic cyc(input logic r, input logic c, input logic [2:0] v,
                     input logic b, input logic [0:0] s, input logic x);
    rst_n = r; coin = c; coin_val = v; buy = b; sel = s; cancel = x;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(); cyc(1, 0, 0, 0, 0, 0); endtask

  int cnt;

  initial begin
    rst_n = 0; coin = 0; coin_val = 0; buy = 0; sel = 0; cancel = 0;
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("rst_credit", 32'(credit), 0);
    chk("rst_busy",   32'(busy), 0);
    chk("rst_vsel",   32'(vend_sel), 0);

    // two coins of 2, buy product 0 at price 3, one unit back
    cyc(1, 1, 2, 0, 0, 0);
    cyc(1, 1, 2, 0, 0, 0);
    chk("acc_credit", 32'(credit), 4);
    cyc(1, 0, 0, 1, 0, 0);
    chk("buy0_vend", 32'(vend), 1);
    chk("buy0_sel",  32'(vend_sel), 0);
    chk("buy0_left", 32'(credit), 1);
    idle();
    chk("buy0_chg", 32'(change), 1);
    idle();
    chk("buy0_done_chg", 32'(change), 0);
    chk("buy0_done_cr",  32'(credit), 0);
    chk("buy0_done_bsy", 32'(busy), 0);

    // insufficient credit denial, then exact purchase with no change
    cyc(1, 1, 2, 0, 0, 0);
    cyc(1, 1, 2, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0);
    chk("deny_pulse",  32'(deny), 1);
    chk("deny_credit", 32'(credit), 4);
    cyc(1, 1, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 1, 0);
    chk("buy1_vend", 32'(vend), 1);
    chk("buy1_sel",  32'(vend_sel), 1);
    idle();
    chk("buy1_nochg", 32'(change), 0);
    chk("buy1_idle",  32'(busy), 0);

    // ceiling: 14 + 2 rejected, 14 + 1 accepted
    cyc(1, 1, 7, 0, 0, 0);
    cyc(1, 1, 7, 0, 0, 0);
    cyc(1, 1, 2, 0, 0, 0);
    chk("ceil_rej",    32'(coin_reject), 1);
    chk("ceil_credit", 32'(credit), 14);
    cyc(1, 1, 1, 0, 0, 0);
    chk("ceil_full", 32'(credit), 15);
    cyc(1, 0, 0, 0, 0, 1);
    cnt = 1;
    for (int i = 0; i < 20 && change; i++) begin idle(); if (change) cnt++; end
    chk("refund15_pulses", 32'(cnt), 15);
    chk("refund15_credit", 32'(credit), 0);

    // cancel beats buy and coin; disturbances during refund do not alter it
    cyc(1, 1, 6, 0, 0, 0);
    cyc(1, 1, 1, 1, 0, 1);
    chk("cx_rej",  32'(coin_reject), 1);
    chk("cx_vend", 32'(vend), 0);
    chk("cx_chg",  32'(change), 1);
    cnt = 1;
    cyc(1, 1, 1, 1, 0, 0);
    chk("busy_rej",  32'(coin_reject), 1);
    chk("busy_deny", 32'(deny), 1);
    if (change) cnt++;
    for (int i = 0; i < 20 && change; i++) begin idle(); if (change) cnt++; end
    chk("refund6_pulses", 32'(cnt), 6);
    chk("refund6_credit", 32'(credit), 0);

    // reset during the third of five refund pulses
    cyc(1, 1, 5, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 1);
    idle();
    idle();
    chk("mid_third", 32'(credit), 3);
    cyc(0, 0, 0, 0, 0, 0);
    chk("mid_rst_credit", 32'(credit), 0);
    chk("mid_rst_chg",    32'(change), 0);
    chk("mid_rst_busy",   32'(busy), 0);
    cyc(1, 1, 3, 0, 0, 0);
    chk("post_rst_coin", 32'(credit), 3);

    // randomized traffic, checked each cycle by the model
    for (int i = 0; i < 3000; i++) begin
      logic r, c, b, x;
      r = ($urandom_range(0, 299) != 0);
      c = ($urandom_range(0, 9) < 4);
      b = ($urandom_range(0, 9) < 2);
      x = ($urandom_range(0, 19) == 0);
      // buy together with cancel at zero credit is left unexercised
      if (x && b && m_credit == 0) b = 0;
      cyc(r, c, 3'($urandom_range(0, 7)), b, 1'($urandom_range(0, 1)), x);
    end

    idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
Parametrised successor to the single-coin, single-product coffee vending controller. It accepts coins of variable value and accumulates credit up to a ceiling. It sells one of N_PROD products at per-product prices, then returns change automatically, one unit per cycle. A cancel input refunds the whole credit. It sits between the coin/button front-end and the dispenser/change-hopper actuators.

Parameters:
N_PROD, 2, number of selectable products
SEL_W, 1, width of product select (must satisfy 2**SEL_W >= N_PROD)
VAL_W, 3, width of coin value input, in credit units
CREDIT_W, 5, width of credit register
MAX_CREDIT, 15, credit ceiling; must be < 2**CREDIT_W
PRICES, {5'd5,5'd3}, packed prices, CREDIT_W bits each; product i at [i*CREDIT_W +: CREDIT_W]; every price must be >= 1

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset, sampled on rising clk
coin  in  1  coin-present strobe, one coin per cycle high
coin_val  in  VAL_W  value of the coin in units, valid when coin=1; 0 is treated as reject
buy  in  1  purchase request strobe
sel  in  SEL_W  product select, sampled with buy
cancel  in  1  refund request
vend  out  1  one-cycle dispense pulse
vend_sel  out  SEL_W  product being dispensed, valid with vend
change  out  1  one pulse per returned credit unit
coin_reject  out  1  one-cycle pulse: coin not accepted
deny  out  1  one-cycle pulse: buy refused
credit  out  CREDIT_W  current credit
busy  out  1  high in VEND and CHANGE states

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE, credit=0, all pulse outputs=0, vend_sel=0, busy=0. Reset applied mid-VEND or mid-CHANGE aborts; outstanding change is lost.
- All outputs are registered. Pulses are high for exactly one cycle, in the cycle after the decision edge.
- States: IDLE (credit=0), CREDIT (credit>0), VEND, CHANGE.
- Priority in IDLE/CREDIT, evaluated per cycle: cancel > buy > coin.
- cancel with credit>0 -> CHANGE. With credit=0 it is ignored.
- buy: if sel>=N_PROD or credit<PRICES[sel] -> deny=1, state and credit unchanged. Otherwise -> VEND, vend_sel<=sel, credit<=credit-PRICES[sel].
- coin, when no cancel or buy: if coin_val!=0 and credit+coin_val<=MAX_CREDIT, credit accumulates (sum computed CREDIT_W+1 wide, no wrap) and state -> CREDIT. Otherwise coin_reject=1 and credit is unchanged.
- Coin in the same cycle as cancel or buy -> coin_reject=1.
- VEND: lasts one cycle, vend=1. Next state is CHANGE if credit>0, else IDLE.
- CHANGE: each cycle change=1 and credit decrements by 1. When credit reaches 0 the state goes to IDLE. The number of change pulses equals the credit at CHANGE entry.
- In VEND/CHANGE: coin -> coin_reject=1; buy -> deny=1; cancel is ignored.
- Latency: buy at edge t -> vend high in cycle t+1 -> first change pulse in t+2.

Decomposition:
- Package vending_pkg: state encoding (IDLE=2'd0, CREDIT=2'd1, VEND=2'd2, CHANGE=2'd3) and a price-extract function.
- No sub-module. A single FSM plus the credit datapath fits in one module.

Test Plan:
- Reset, then coin=1 val=2 twice -> credit=4, state=CREDIT. buy sel=0 (price 3) -> vend=1, vend_sel=0 next cycle, then exactly 1 change pulse, then IDLE with credit=0.
- Credit 4, buy sel=1 (price 5) -> deny=1 for one cycle, credit stays 4. Add coin val=1, buy sel=1 -> vend, 0 change pulses.
- Credit 14, coin val=2 -> coin_reject=1, credit stays 14. Coin val=1 -> credit 15.
- Credit 6, cancel with coin and buy asserted in the same cycle -> coin_reject=1, no vend, 6 consecutive change pulses, credit 0.
- During the CHANGE sequence, assert coin val=1 and buy -> coin_reject and deny pulses; change count unaffected.
- Reset asserted during the 3rd of 5 change pulses -> next cycle credit=0, all outputs 0, IDLE. A coin afterwards is accepted normally.
